reg_file: RTL and testbench

Architectural register file and write scoreboard for the flat RISC-V pipeline. Accepts retiring results (`data`, `address`) from the write stage through a valid/ready handshake and serves two registered read ports to decode. Tracks in-flight destination writes per register and flags read-after-write hazards so decode can stall. x0 is hardwired to zero.

---
 rtl/rv_pkg.sv | 16 +
 rtl/reg_file_if.sv | 31 +++
 rtl/reg_file_pend_counter.sv | 36 +++
 rtl/reg_file.sv | 121 ++++++++++++
 tb/tb_reg_file.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline types: the architectural word, the register address, and the x0 index.
package rv_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  function automatic logic isRealReg(input reg_addr_t addr);
    return addr != REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Write-stage result and decode read/claim bundle between the pipeline and the register file.
interface reg_file_if;
  import rv_pkg::*;

  word_t     w_data;
  reg_addr_t w_address;
  logic      w_v;
  logic      w_r;

  reg_addr_t rs1_addr;
  reg_addr_t rs2_addr;
  reg_addr_t rd_claim;
  logic      d_v;
  logic      d_r;

  word_t     rs1_data;
  word_t     rs2_data;
  logic      q_v;
  logic      hazard;

  modport master (
    output w_data, w_address, w_v, rs1_addr, rs2_addr, rd_claim, d_v,
    input  w_r, d_r, rs1_data, rs2_data, q_v, hazard
  );

  modport slave (
    input  w_data, w_address, w_v, rs1_addr, rs2_addr, rd_claim, d_v,
    output w_r, d_r, rs1_data, rs2_data, q_v, hazard
  );

endinterface

// File: rtl/reg_file_pend_counter.sv
// Saturating up/down count of in-flight writes to one register; inc and dec together hold.
module pend_counter #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o
);
  import rv_pkg::*;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // A retire with nothing outstanding (e.g. claimed before a reset) is dropped.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/reg_file.sv
// Architectural register file with per-register write scoreboard; x0 reads zero and never hazards.
// Define REG_FILE_BYPASS_EN to forward a same-cycle retiring write into the read and its hazard check.
module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 2
) (
  input  logic     clk,
  input  logic     rst,
  reg_file_if.slave bus
);
  import rv_pkg::*;

  logic                       wReady_q;
  logic                       wAcc;
  logic                       dAcc;
  logic [NREG-1:0][CW-1:0]    pendCnt;
  logic [XLEN-1:0]            regs_q [NREG];
  logic [XLEN-1:0]            rs1Data_q;
  logic [XLEN-1:0]            rs1Data_d;
  logic [XLEN-1:0]            rs2Data_q;
  logic [XLEN-1:0]            rs2Data_d;
  logic                       qValid_q;
  logic                       hazard_q;
  logic                       hazard_d;
  logic                       rs1Busy;
  logic                       rs2Busy;

  // Ready drops while reset is held and returns on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wReady_q <= 1'b0;
    end else begin
      wReady_q <= 1'b1;
    end
  end

  assign bus.w_r = wReady_q;
  assign wAcc    = bus.w_v && wReady_q && isRealReg(bus.w_address);
  assign bus.d_r = !(isRealReg(bus.rd_claim) && (pendCnt[bus.rd_claim] == '1));
  assign dAcc    = bus.d_v && bus.d_r;

  assign pendCnt[0] = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_pend
    pend_counter #(
      .CW (CW)
    ) u_pend (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (dAcc && (bus.rd_claim == AW'(i))),
      .dec_i   (wAcc && (bus.w_address == AW'(i))),
      .count_o (pendCnt[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wAcc) begin
      regs_q[bus.w_address] <= bus.w_data;
    end
  end

  // With forwarding, a write retiring this cycle no longer counts against its register.
  always_comb begin
`ifdef REG_FILE_BYPASS_EN
    rs1Busy = (pendCnt[bus.rs1_addr] > CW'(1)) ||
              ((pendCnt[bus.rs1_addr] == CW'(1)) &&
               !(wAcc && (bus.w_address == bus.rs1_addr)));
    rs2Busy = (pendCnt[bus.rs2_addr] > CW'(1)) ||
              ((pendCnt[bus.rs2_addr] == CW'(1)) &&
               !(wAcc && (bus.w_address == bus.rs2_addr)));
`else
    rs1Busy = pendCnt[bus.rs1_addr] != '0;
    rs2Busy = pendCnt[bus.rs2_addr] != '0;
`endif
  end

  always_comb begin
    rs1Data_d = rs1Data_q;
    rs2Data_d = rs2Data_q;
    hazard_d  = hazard_q;
    if (dAcc) begin
      rs1Data_d = regs_q[bus.rs1_addr];
      rs2Data_d = regs_q[bus.rs2_addr];
`ifdef REG_FILE_BYPASS_EN
      if (wAcc && (bus.w_address == bus.rs1_addr)) begin
        rs1Data_d = bus.w_data;
      end
      if (wAcc && (bus.w_address == bus.rs2_addr)) begin
        rs2Data_d = bus.w_data;
      end
`endif
      hazard_d = rs1Busy || rs2Busy;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1Data_q <= '0;
      rs2Data_q <= '0;
      qValid_q  <= 1'b0;
      hazard_q  <= 1'b0;
    end else begin
      rs1Data_q <= rs1Data_d;
      rs2Data_q <= rs2Data_d;
      qValid_q  <= dAcc;
      hazard_q  <= hazard_d;
    end
  end

  assign bus.rs1_data = rs1Data_q;
  assign bus.rs2_data = rs2Data_q;
  assign bus.q_v      = qValid_q;
  assign bus.hazard   = hazard_q;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed vector table, reset sequence, then random traffic against a model.
module tb_reg_file;
  import rv_pkg::*;

  logic clk = 1'b0;
  logic rst;

  reg_file_if bus ();

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic      wv;
    reg_addr_t wa;
    word_t     wd;
    logic      dv;
    reg_addr_t r1;
    reg_addr_t r2;
    reg_addr_t cl;
    logic      eDr;
    logic      eQv;
    word_t     eRs1;
    word_t     eRs2;
    logic      eHaz;
  } vec_t;

`ifdef REG_FILE_BYPASS_EN
  localparam word_t BypRs1 = 32'h0000A5A5;
  localparam logic  BypHaz = 1'b0;
`else
  localparam word_t BypRs1 = 32'h0;
  localparam logic  BypHaz = 1'b1;
`endif

  int    checks   = 0;
  int    failures = 0;
  vec_t  vecs [21];

  // Reference state: register contents and outstanding write counts per register.
  word_t mdlRegs [32];
  int    mdlPend [32];
  logic  mdlWr;
  logic  mdlWrPre;
  logic  mdlDr;
  logic  mdlQv;
  logic  mdlHaz;
  word_t mdlRs1;
  word_t mdlRs2;
  logic  sampDr;
  logic  sampWr;

  function automatic vec_t mkVec(input int wv, input int wa, input int wd, input int dv,
                                 input int r1, input int r2, input int cl, input int eDr,
                                 input int eQv, input int eRs1, input int eRs2, input int eHaz);
    vec_t v;
    v.wv = 1'(wv);   v.wa = reg_addr_t'(wa); v.wd = word_t'(wd);   v.dv = 1'(dv);
    v.r1 = reg_addr_t'(r1); v.r2 = reg_addr_t'(r2); v.cl = reg_addr_t'(cl);
    v.eDr = 1'(eDr); v.eQv = 1'(eQv); v.eRs1 = word_t'(eRs1); v.eRs2 = word_t'(eRs2);
    v.eHaz = 1'(eHaz);
    return v;
  endfunction

  task automatic mdlReset();
    for (int i = 0; i < 32; i++) begin
      mdlRegs[i] = '0;
      mdlPend[i] = 0;
    end
    mdlWr  = 1'b0;
    mdlQv  = 1'b0;
    mdlRs1 = '0;
    mdlRs2 = '0;
    mdlHaz = 1'b0;
  endtask

  function automatic word_t mdlRead(input reg_addr_t a, input logic wacc, input reg_addr_t wa,
                                    input word_t wd);
    if (a == 5'd0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (wacc && (wa == a)) return wd;
`endif
    return mdlRegs[a];
  endfunction

  function automatic logic mdlBusy(input reg_addr_t a, input logic wacc, input reg_addr_t wa);
    int cnt;
    cnt = mdlPend[a];
`ifdef REG_FILE_BYPASS_EN
    if (wacc && (wa == a) && (cnt > 0)) cnt = cnt - 1;
`endif
    return (a != 5'd0) && (cnt > 0);
  endfunction

  task automatic checkOutput(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic eDr, input logic eWr, input logic eQv,
                          input word_t eRs1, input word_t eRs2, input logic eHaz);
    checkOutput({tag, "_d_r"}, word_t'(sampDr), word_t'(eDr));
    checkOutput({tag, "_w_r"}, word_t'(sampWr), word_t'(eWr));
    checkOutput({tag, "_q_v"}, word_t'(bus.q_v), word_t'(eQv));
    checkOutput({tag, "_rs1"}, bus.rs1_data, eRs1);
    checkOutput({tag, "_rs2"}, bus.rs2_data, eRs2);
    checkOutput({tag, "_hazard"}, word_t'(bus.hazard), word_t'(eHaz));
  endtask

  // Drives one cycle at the falling edge, samples the handshakes, then advances the model.
  task automatic applyStimulus(input logic wv, input reg_addr_t wa, input word_t wd,
                               input logic dv, input reg_addr_t r1, input reg_addr_t r2,
                               input reg_addr_t cl);
    logic wacc;
    logic dacc;
    bus.w_v = wv; bus.w_address = wa; bus.w_data = wd;
    bus.d_v = dv; bus.rs1_addr = r1; bus.rs2_addr = r2; bus.rd_claim = cl;
    #1;
    sampDr   = bus.d_r;
    sampWr   = bus.w_r;
    mdlWrPre = mdlWr;
    mdlDr    = !((cl != 5'd0) && (mdlPend[cl] == 3));
    @(posedge clk);
    wacc = wv && mdlWr && (wa != 5'd0);
    dacc = dv && mdlDr;
    mdlQv = dacc;
    if (dacc) begin
      mdlRs1 = mdlRead(r1, wacc, wa, wd);
      mdlRs2 = mdlRead(r2, wacc, wa, wd);
      mdlHaz = mdlBusy(r1, wacc, wa) || mdlBusy(r2, wacc, wa);
    end
    if (wacc) mdlRegs[wa] = wd;
    if (!(wacc && dacc && (wa == cl))) begin
      if (wacc && (mdlPend[wa] > 0)) mdlPend[wa] = mdlPend[wa] - 1;
      if (dacc && (cl != 5'd0) && (mdlPend[cl] < 3)) mdlPend[cl] = mdlPend[cl] + 1;
    end
    mdlWr = 1'b1;
    #1;
  endtask

  initial begin
    //                wv wa wd            dv r1 r2 cl  dr qv rs1           rs2    haz
    vecs[0]  = mkVec(0, 0, 0,            0, 0, 0, 0,  1, 0, 0,            0,     0);
    vecs[1]  = mkVec(1, 3, 32'hDEADBEEF, 0, 0, 0, 0,  1, 0, 0,            0,     0);
    vecs[2]  = mkVec(0, 0, 0,            1, 3, 0, 0,  1, 1, 32'hDEADBEEF, 0,     0);
    vecs[3]  = mkVec(1, 0, 32'h1234,     0, 0, 0, 0,  1, 0, 32'hDEADBEEF, 0,     0);
    vecs[4]  = mkVec(0, 0, 0,            1, 0, 0, 0,  1, 1, 0,            0,     0);
    vecs[5]  = mkVec(0, 0, 0,            1, 0, 0, 7,  1, 1, 0,            0,     0);
    vecs[6]  = mkVec(0, 0, 0,            1, 3, 7, 0,  1, 1, 32'hDEADBEEF, 0,     1);
    vecs[7]  = mkVec(1, 7, 32'h55,       0, 0, 0, 0,  1, 0, 32'hDEADBEEF, 0,     1);
    vecs[8]  = mkVec(0, 0, 0,            1, 7, 7, 0,  1, 1, 32'h55,       32'h55, 0);
    vecs[9]  = mkVec(0, 0, 0,            1, 0, 0, 9,  1, 1, 0,            0,     0);
    vecs[10] = mkVec(0, 0, 0,            1, 0, 0, 9,  1, 1, 0,            0,     0);
    vecs[11] = mkVec(0, 0, 0,            1, 0, 0, 9,  1, 1, 0,            0,     0);
    vecs[12] = mkVec(0, 0, 0,            1, 0, 0, 9,  0, 0, 0,            0,     0);
    vecs[13] = mkVec(1, 9, 32'h99,       0, 0, 0, 9,  0, 0, 0,            0,     0);
    vecs[14] = mkVec(0, 0, 0,            1, 0, 0, 9,  1, 1, 0,            0,     0);
    vecs[15] = mkVec(0, 0, 0,            1, 0, 0, 4,  1, 1, 0,            0,     0);
    vecs[16] = mkVec(1, 4, 32'h44,       1, 0, 0, 4,  1, 1, 0,            0,     0);
    vecs[17] = mkVec(0, 0, 0,            1, 4, 0, 0,  1, 1, 32'h44,       0,     1);
    vecs[18] = mkVec(0, 0, 0,            1, 0, 0, 6,  1, 1, 0,            0,     0);
    vecs[19] = mkVec(1, 6, 32'hA5A5,     1, 6, 0, 0,  1, 1, int'(BypRs1), 0,     int'(BypHaz));
    vecs[20] = mkVec(0, 0, 0,            1, 6, 0, 0,  1, 1, 32'hA5A5,     0,     0);

    rst = 1'b1;
    bus.w_v = 1'b0; bus.w_address = '0; bus.w_data = '0;
    bus.d_v = 1'b0; bus.rs1_addr = '0; bus.rs2_addr = '0; bus.rd_claim = '0;
    mdlReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    sampDr = bus.d_r;
    sampWr = bus.w_r;
    checkAll("rst", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].dv,
                    vecs[i].r1, vecs[i].r2, vecs[i].cl);
      checkAll($sformatf("vec%0d", i), vecs[i].eDr, (i != 0), vecs[i].eQv,
               vecs[i].eRs1, vecs[i].eRs2, vecs[i].eHaz);
      @(negedge clk);
    end

    // x9 is saturated here; an asynchronous reset must clear the count and every output.
    bus.w_v = 1'b0; bus.d_v = 1'b1; bus.rd_claim = 5'd9; bus.rs1_addr = 5'd9; bus.rs2_addr = 5'd0;
    #1;
    checkOutput("presrst_d_r", word_t'(bus.d_r), 32'h0);
    #1;
    rst = 1'b1;
    #1;
    sampDr = bus.d_r;
    sampWr = bus.w_r;
    checkAll("midrst", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mdlReset();

    applyStimulus(1'b0, 5'd0, '0,           1'b0, 5'd0, 5'd0, 5'd0);
    checkAll("postrst_idle", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, '0,           1'b1, 5'd5, 5'd9, 5'd0);
    checkAll("postrst_rd5", 1'b1, 1'b1, 1'b1, '0, '0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 5'd9, 32'h77,       1'b0, 5'd0, 5'd0, 5'd0);
    checkAll("postrst_wr9", 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, '0,           1'b1, 5'd9, 5'd0, 5'd9);
    checkAll("postrst_rd9", 1'b1, 1'b1, 1'b1, 32'h77, '0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, '0,           1'b1, 5'd0, 5'd9, 5'd0);
    checkAll("postrst_haz9", 1'b1, 1'b1, 1'b1, '0, 32'h77, 1'b1);
    @(negedge clk);

    for (int n = 0; n < 500; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), reg_addr_t'($urandom_range(0, 7)), word_t'($urandom),
                    ($urandom_range(0, 3) != 0), reg_addr_t'($urandom_range(0, 7)),
                    reg_addr_t'($urandom_range(0, 7)), reg_addr_t'($urandom_range(0, 7)));
      checkAll($sformatf("rnd%0d", n), mdlDr, mdlWrPre, mdlQv, mdlRs1, mdlRs2, mdlHaz);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
